// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// ------------------------------------------------------------------------
// Data-memory access controller for the MEM stage. It takes the load or
// store held in EX/MEM, runs one request/response transaction on the
// data-memory bus and holds the whole pipeline with mem_stall until the
// transaction has finished. Store lanes and byte enables are formed here,
// and so are load lane extraction and sign/zero extension.
//
// Parameters
//   TIMEOUT_CYCLES  most cycles allowed in REQ+RESP before the access is
//                   aborted (0 = never abort), legal range 0..65535
//
// Optional feature
//   DMEM_MISALIGN_CHK_EN  when defined, misaligned H/HU/W accesses go
//                         straight to DONE with access_err and no bus
//                         request
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   req_valid        EX/MEM holds a load or store this cycle
//   req_we           1 = store, 0 = load
//   req_funct3       RISC-V width/sign (B, H, W, BU, HU)
//   req_addr         byte address
//   req_wdata        store data (rs2)
//   read_data        extended load data to MEM/WB (registered, held)
//   mem_stall        hold all pipeline registers (combinational)
//   access_err       one-cycle pulse in DONE when the access was aborted
//   dm_req/dm_we     bus request / write (registered)
//   dm_addr          word address, low two bits zero (registered)
//   dm_wdata/dm_be   lane-replicated store data / byte enables (registered)
//   dm_gnt           request accepted
//   dm_rvalid        response valid (loads and stores)
//   dm_rdata         read word
// ------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] read_data,
  output logic        mem_stall,
  output logic        access_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [15:0] TIMEOUT_LIM = TIMEOUT_CYCLES[15:0];

  // Byte enables for a given width and byte offset (loads use the same).
  function automatic logic [3:0] calc_be(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      3'b000, 3'b100: be = 4'b0001 << off;
      3'b001, 3'b101: be = off[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the width could occupy.
  function automatic logic [31:0] calc_wdata(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
    logic [31:0] res;
    case (funct3)
      3'b000, 3'b100: res = {4{wdata[7:0]}};
      3'b001, 3'b101: res = {2{wdata[15:0]}};
      default:        res = wdata;
    endcase
    return res;
  endfunction

  // Pick the addressed lane out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] res;
    case (off)
      2'd0:    b_lane = rdata[7:0];
      2'd1:    b_lane = rdata[15:8];
      2'd2:    b_lane = rdata[23:16];
      2'd3:    b_lane = rdata[31:24];
      default: b_lane = 8'h00;
    endcase
    h_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  res = {{24{b_lane[7]}}, b_lane};
      3'b100:  res = {24'h000000, b_lane};
      3'b001:  res = {{16{h_lane[15]}}, h_lane};
      3'b101:  res = {16'h0000, h_lane};
      default: res = rdata;
    endcase
    return res;
  endfunction

`ifdef DMEM_MISALIGN_CHK_EN
  // Halfword with odd address, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic mis;
    case (funct3)
      3'b001, 3'b101: mis = off[0];
      3'b010:         mis = (off != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  logic [1:0]  state_q,      state_d;
  logic [15:0] cnt_q,        cnt_d;
  logic [2:0]  funct3_q,     funct3_d;
  logic [1:0]  off_q,        off_d;
  logic        dm_req_q,     dm_req_d;
  logic        dm_we_q,      dm_we_d;
  logic [31:0] dm_addr_q,    dm_addr_d;
  logic [31:0] dm_wdata_q,   dm_wdata_d;
  logic [3:0]  dm_be_q,      dm_be_d;
  logic [31:0] read_data_q,  read_data_d;
  logic        access_err_q, access_err_d;

  logic        misalign_s;
  logic        cnt_hit_s;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign_s = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Counter starts at 0 in the first REQ cycle, so hitting LIM-1 means
  // exactly TIMEOUT_CYCLES cycles have been spent in REQ+RESP.
  assign cnt_hit_s = TIMEOUT_EN && (cnt_q == (TIMEOUT_LIM - 16'd1));

  // DONE is deliberately excluded so the finishing instruction is not reissued.
  assign mem_stall = ((state_q == S_IDLE) && req_valid) ||
                     (state_q == S_REQ) || (state_q == S_RESP);

  assign read_data  = read_data_q;
  assign access_err = access_err_q;
  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_be      = dm_be_q;

  // Next-state, bus-field and result computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    dm_be_d      = dm_be_q;
    read_data_d  = read_data_q;
    access_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (misalign_s) begin
            state_d      = S_DONE;
            read_data_d  = 32'h0000_0000;
            access_err_d = 1'b1;
          end else begin
            state_d    = S_REQ;
            cnt_d      = 16'd0;
            funct3_d   = req_funct3;
            off_d      = req_addr[1:0];
            dm_req_d   = 1'b1;
            dm_we_d    = req_we;
            dm_addr_d  = {req_addr[31:2], 2'b00};
            dm_wdata_d = calc_wdata(req_funct3, req_wdata);
            dm_be_d    = calc_be(req_funct3, req_addr[1:0]);
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        // Timeout takes priority over a grant arriving on the last cycle.
        if (cnt_hit_s) begin
          state_d      = S_DONE;
          dm_req_d     = 1'b0;
          read_data_d  = 32'h0000_0000;
          access_err_d = 1'b1;
        end else if (dm_gnt) begin
          state_d  = S_RESP;
          dm_req_d = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end

      S_RESP: begin
        cnt_d = cnt_q + 16'd1;
        // A response on the last allowed cycle still completes normally.
        if (dm_rvalid) begin
          state_d     = S_DONE;
          read_data_d = dm_we_q ? 32'h0000_0000
                                : load_extract(funct3_q, off_q, dm_rdata);
        end else if (cnt_hit_s) begin
          state_d      = S_DONE;
          read_data_d  = 32'h0000_0000;
          access_err_d = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= 32'h0000_0000;
      dm_wdata_q   <= 32'h0000_0000;
      dm_be_q      <= 4'b0000;
      read_data_q  <= 32'h0000_0000;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_be_q      <= dm_be_d;
      read_data_q  <= read_data_d;
      access_err_q <= access_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed cases followed by randomized
// loads/stores with random grant/response latency, checked against a
// transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        access_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  int checks_n = 0;
  int errors_n = 0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .read_data  (read_data),
    .mem_stall  (mem_stall),
    .access_err (access_err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_be      (dm_be),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load result from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0]  f3,
                                             input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (32'd8 * 32'(a[1:0]))) & 32'h0000_00FF;
        if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (rd >> (32'd16 * 32'(a[1]))) & 32'h0000_FFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic model_misaligned(input logic [2:0]  f3,
                                            input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    return ((f3 == 3'b001 || f3 == 3'b101) && a[0]) ||
           (f3 == 3'b010 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One transaction. Entered at a falling edge; g = REQ cycles before
  // grant, r = RESP cycles before response (g large = never granted).
  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int g, input int r);
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        mis;
    logic        tmo;
    logic        done;
    int          exp_stall;
    int          stall;
    int          phase;
    int          wcnt;

    mis      = model_misaligned(f3, addr);
    tmo      = !mis && ((g + 1 >= TMO) || (g + r + 2 > TMO));
    exp_addr = addr & 32'hFFFF_FFFC;
    case (f3)
      3'b000, 3'b100: begin
        exp_be = 4'b0001 << addr[1:0];
        exp_wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
      end
      3'b001, 3'b101: begin
        exp_be = addr[1] ? 4'b1100 : 4'b0011;
        exp_wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
      end
      default: begin
        exp_be = 4'b1111;
        exp_wd = wdata;
      end
    endcase
    if (mis)      exp_stall = 1;
    else if (tmo) exp_stall = 1 + TMO;
    else          exp_stall = 3 + g + r;
    exp_rd = (mis || tmo || we) ? 32'd0 : model_load(f3, addr, rdata);

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    dm_rdata   = rdata;
    stall = 0; phase = 0; wcnt = 0; done = 1'b0;

    for (int c = 0; c < 64; c++) begin
      #1;
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stall++;
      if (dm_req) begin
        if (phase == 0) begin
          phase = 1;
          wcnt  = 0;
        end
        check_val("req_addr", dm_addr, exp_addr);
        check_val("req_be", 32'(dm_be), 32'(exp_be));
        check_val("req_we", 32'(dm_we), 32'(we));
        if (we) check_val("req_wdata", dm_wdata, exp_wd);
        dm_gnt    = (wcnt == g);
        dm_rvalid = 1'($urandom_range(0, 1));
        wcnt++;
        if (dm_gnt) begin
          phase = 2;
          wcnt  = 0;
        end
      end else if (phase == 2) begin
        dm_gnt    = 1'b0;
        dm_rvalid = (wcnt == r);
        wcnt++;
      end else begin
        dm_gnt    = 1'b0;
        dm_rvalid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end

    dm_gnt = 1'b0;
    check_val("txn_completes", 32'(done), 32'd1);
    check_val("stall_cycles", 32'(stall), 32'(exp_stall));
    check_val("bus_used", 32'(phase != 0), 32'(!mis));
    check_val("done_read_data", read_data, exp_rd);
    check_val("done_access_err", 32'(access_err), 32'(mis || tmo));

    // Stray response in DONE and the following IDLE must be ignored.
    dm_rvalid = 1'b1;
    dm_rdata  = ~rdata;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_val("err_one_cycle", 32'(access_err), 32'd0);
    check_val("read_data_hold", read_data, exp_rd);
    check_val("idle_no_req", 32'(dm_req), 32'd0);
    dm_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_read_data"}, read_data, 32'd0);
    check_val({tag, "_mem_stall"}, 32'(mem_stall), 32'd0);
    check_val({tag, "_access_err"}, 32'(access_err), 32'd0);
    check_val({tag, "_dm_req"}, 32'(dm_req), 32'd0);
    check_val({tag, "_dm_we"}, 32'(dm_we), 32'd0);
    check_val({tag, "_dm_addr"}, dm_addr, 32'd0);
    check_val({tag, "_dm_wdata"}, dm_wdata, 32'd0);
    check_val({tag, "_dm_be"}, 32'(dm_be), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_tmp;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // LB at 0x1003, sign-extended top byte.
    run_txn(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h8000_0000, 0, 0);
    check_val("lb_value", read_data, 32'hFFFF_FF80);
    @(negedge clk);

    // SH at 0x2002.
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
    check_val("sh_read_data", read_data, 32'd0);
    @(negedge clk);

    // Grant never arrives: abort after TMO REQ cycles.
    run_txn(1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'h1111_2222, 99, 0);
    @(negedge clk);

    // LW at 0x1001: aborted with the check, whole word otherwise.
    run_txn(1'b0, 3'b010, 32'h0000_1001, 32'd0, 32'hCAFE_F00D, 0, 1);
    @(negedge clk);

    // LHU with grant 2 cycles late and response 3 cycles late.
    run_txn(1'b0, 3'b101, 32'h0000_4002, 32'd0, 32'hBEEF_1234, 2, 3);
    check_val("lhu_value", read_data, 32'h0000_BEEF);
    @(negedge clk);

    // Reset while waiting for the response.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_5000; dm_rdata = 32'h7777_7777;
    @(negedge clk);
    #1;
    check_val("rst_pre_req", 32'(dm_req), 32'd1);
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    #1;
    check_val("rst_in_resp_stall", 32'(mem_stall), 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 3'b000, 32'h0000_6001, 32'd0, 32'h0000_7F00, 1, 1);
    check_val("post_rst_lb", read_data, 32'h0000_007F);
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int g;
      int r;
      g = int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) g = 99;
      rd_tmp = $urandom;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              $urandom, rd_tmp, g, r);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
